hilo_muldiv: RTL



---
 rtl/hilo_muldiv_if.sv | 31 +++
 rtl/hilo_muldiv.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_if.sv
// ============================================================================
// Module      : hilo_muldiv_if
// Description : EX-stage to HI/LO unit bundle (operation, operands, results).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hilo_muldiv_if;
    logic        ex_valid_i;
    logic        stall_i;
    logic        flush_i;
    logic [8:0]  hilo_op_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        stallreq_o;
    logic [31:0] hilo_res_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output ex_valid_i, stall_i, flush_i, hilo_op_i, src1_i, src2_i,
        input  stallreq_o, hilo_res_o, hi_o, lo_o
    );

    modport slave (
        input  ex_valid_i, stall_i, flush_i, hilo_op_i, src1_i, src2_i,
        output stallreq_o, hilo_res_o, hi_o, lo_o
    );
endinterface

`default_nettype wire

// File: rtl/hilo_muldiv.sv
// ============================================================================
// Module      : hilo_muldiv
// Description : HI/LO register owner: moves, single-cycle multiplies and a
//               32-step restoring divider that stalls the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv #(
    parameter int DIV_ITER = 32
) (
    input wire           clk,
    input wire           rst,
    hilo_muldiv_if.slave bus
);

    localparam int            c_cw        = $clog2(DIV_ITER);
    localparam logic [c_cw-1:0] c_last_iter = c_cw'(DIV_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_cw-1:0] r_cnt;
    logic [31:0]     r_quot;
    logic [31:0]     r_rem;
    logic [31:0]     r_divisor;
    logic [31:0]     r_dividend_raw;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div0;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;

    // Operation decode; bit order {mfhi,mflo,mthi,mtlo,mult,multu,div,divu,mul}
    logic w_op_mfhi, w_op_mflo, w_op_mthi, w_op_mtlo;
    logic w_op_mult, w_op_multu, w_op_div, w_op_divu, w_op_mul;
    assign w_op_mfhi  = bus.hilo_op_i[8];
    assign w_op_mflo  = bus.hilo_op_i[7];
    assign w_op_mthi  = bus.hilo_op_i[6];
    assign w_op_mtlo  = bus.hilo_op_i[5];
    assign w_op_mult  = bus.hilo_op_i[4];
    assign w_op_multu = bus.hilo_op_i[3];
    assign w_op_div   = bus.hilo_op_i[2];
    assign w_op_divu  = bus.hilo_op_i[1];
    assign w_op_mul   = bus.hilo_op_i[0];

    logic w_is_div;
    logic w_we;
    logic w_issue;
    assign w_is_div = w_op_div | w_op_divu;
    assign w_we     = bus.ex_valid_i & ~bus.flush_i & ~bus.stall_i;
    assign w_issue  = bus.ex_valid_i & w_is_div & ~bus.flush_i;

    assign bus.stallreq_o = w_issue & (r_state != S_DONE);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    assign w_prod_s = $signed({{32{bus.src1_i[31]}}, bus.src1_i}) *
                      $signed({{32{bus.src2_i[31]}}, bus.src2_i});
    assign w_prod_u = {32'd0, bus.src1_i} * {32'd0, bus.src2_i};

    // Restoring step: shift next dividend bit into the partial remainder
    logic [32:0] w_rem_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    assign w_rem_shift = {r_rem, r_quot[31]};
    assign w_diff      = w_rem_shift - {1'b0, r_divisor};
    assign w_ge        = ~w_diff[32];

    logic [31:0] w_src1_abs;
    logic [31:0] w_src2_abs;
    assign w_src1_abs = (w_op_div & bus.src1_i[31]) ? -bus.src1_i : bus.src1_i;
    assign w_src2_abs = (w_op_div & bus.src2_i[31]) ? -bus.src2_i : bus.src2_i;

    // Divide by zero reports the raw dividend, bypassing sign fixups
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    assign w_q_fix = r_div0  ? 32'hFFFF_FFFF :
                     r_neg_q ? -r_quot : r_quot;
    assign w_r_fix = r_div0  ? r_dividend_raw :
                     r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!bus.ex_valid_i || bus.flush_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_last_iter) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.ex_valid_i || bus.flush_i || w_we) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt          <= '0;
            r_quot         <= '0;
            r_rem          <= '0;
            r_divisor      <= '0;
            r_dividend_raw <= '0;
            r_neg_q        <= 1'b0;
            r_neg_r        <= 1'b0;
            r_div0         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_cnt          <= '0;
                        r_quot         <= w_src1_abs;
                        r_rem          <= '0;
                        r_divisor      <= w_src2_abs;
                        r_dividend_raw <= bus.src1_i;
                        r_neg_q        <= w_op_div & (bus.src1_i[31] ^ bus.src2_i[31]);
                        r_neg_r        <= w_op_div & bus.src1_i[31];
                        r_div0         <= (bus.src2_i == 32'd0);
                    end
                end
                S_BUSY: begin
                    r_cnt  <= r_cnt + c_cw'(1);
                    r_quot <= {r_quot[30:0], w_ge};
                    r_rem  <= w_ge ? w_diff[31:0] : w_rem_shift[31:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_we) begin
            if (w_op_mthi) begin
                r_hi <= bus.src1_i;
            end else if (w_op_mtlo) begin
                r_lo <= bus.src1_i;
            end else if (w_op_mult) begin
                {r_hi, r_lo} <= w_prod_s;
            end else if (w_op_multu) begin
                {r_hi, r_lo} <= w_prod_u;
            end else if (w_is_div && (r_state == S_DONE)) begin
                r_hi <= w_r_fix;
                r_lo <= w_q_fix;
            end
        end
    end

    always_comb begin
        bus.hilo_res_o = 32'd0;
        if (w_op_mfhi) begin
            bus.hilo_res_o = r_hi;
        end else if (w_op_mflo) begin
            bus.hilo_res_o = r_lo;
        end else if (w_op_mul) begin
            bus.hilo_res_o = w_prod_s[31:0];
        end
    end

    assign bus.hi_o = r_hi;
    assign bus.lo_o = r_lo;

endmodule

`default_nettype wire
